// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU and HOST ports.
// One access at a time: the command is captured on grant, issued for one cycle, and read data is returned one cycle later.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_rvalid,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic          host_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  // state | meaning
  // IDLE  | sample requests, grant round-robin
  // ACC   | command on the RAM pins, ack pulsed
  // RD    | RAM read data registered into rdata
  typedef enum logic [1:0] {IDLE, ACC, RD} state_t;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  state_t state;
  logic   gnt;
  logic   last_grant;
  logic   cmd_wr;

  // mem_addr / mem_wdata double as the command registers, so the RAM pins never follow the requesters.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      gnt         <= PORT_CPU;
      last_grant  <= PORT_HOST;
      cmd_wr      <= 1'b0;
      cpu_ack     <= 1'b0;
      host_ack    <= 1'b0;
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      owner       <= 2'b00;
    end else begin
      cpu_ack     <= 1'b0;
      host_ack    <= 1'b0;
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      mem_wr      <= 1'b0;
      case (state)
        IDLE: begin
          owner <= 2'b00;
          if (cpu_req && (!host_req || last_grant == PORT_HOST)) begin
            gnt       <= PORT_CPU;
            cmd_wr    <= cpu_wr;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_wr    <= cpu_wr;
            cpu_ack   <= 1'b1;
            owner     <= 2'b01;
            state     <= ACC;
          end else if (host_req) begin
            gnt       <= PORT_HOST;
            cmd_wr    <= host_wr;
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
            mem_wr    <= host_wr;
            host_ack  <= 1'b1;
            owner     <= 2'b10;
            state     <= ACC;
          end
        end
        ACC: begin
          if (cmd_wr) begin
            last_grant <= gnt;
            owner      <= 2'b00;
            state      <= IDLE;
          end else begin
            state <= RD;
          end
        end
        RD: begin
          rdata       <= mem_rdata;
          cpu_rvalid  <= (gnt == PORT_CPU);
          host_rvalid <= (gnt == PORT_HOST);
          last_grant  <= gnt;
          owner       <= 2'b00;
          state       <= IDLE;
        end
        default: begin
          owner <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized two-port run
// checked against a transaction-level model (memory image, round-robin winner, access latency).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        host_req = 1'b0, host_wr = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        cpu_ack, cpu_rvalid, host_ack, host_rvalid, mem_wr;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic [1:0]  owner;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [15:0] ram [256];
  logic [15:0] exp_mem [256];
  logic        ram_ready = 1'b0;

  dmem_arbiter #(.AW(8), .DW(16)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rvalid(host_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(int i);
    if (i == 5) return 16'h00A5;
    return {8'(i), 8'(255 - i)};
  endfunction

  // RAM model: synchronous write, registered read.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (mem_wr) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    Reset_n  = 1'b0;
    cpu_req  = 1'b0;
    host_req = 1'b0;
    step;
    step;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    step;
    step;
    vectors++; if ({cpu_ack, host_ack, cpu_rvalid, host_rvalid, mem_wr, owner} !== 7'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b want 0", {cpu_ack, host_ack, cpu_rvalid, host_rvalid, mem_wr, owner}); end
    vectors++; if ({mem_addr, mem_wdata} !== 24'h0) begin miscompares++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
    vectors++; if (rdata !== 16'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    Reset_n = 1'b1;
  endtask

  task automatic test_simultaneous;
    do_reset;
    cpu_req = 1'b1;  cpu_wr = 1'b1;  cpu_addr = 8'h01;  cpu_wdata = 16'h1111;
    host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h02; host_wdata = 16'h2222;
    step;
    vectors++; if ({cpu_ack, host_ack} !== 2'b10) begin miscompares++; $display("FAIL sim_first_ack: got cpu/host %b want 10", {cpu_ack, host_ack}); end
    vectors++; if ({owner, mem_wr, mem_addr, mem_wdata} !== {2'b01, 1'b1, 8'h01, 16'h1111}) begin miscompares++; $display("FAIL sim_first_cmd: got %h want %h", {owner, mem_wr, mem_addr, mem_wdata}, {2'b01, 1'b1, 8'h01, 16'h1111}); end
    exp_mem[8'h01] = 16'h1111;
    cpu_req = 1'b0;
    step;
    vectors++; if ({owner, cpu_ack, host_ack, mem_wr} !== 5'b0) begin miscompares++; $display("FAIL sim_gap: got %b want 0", {owner, cpu_ack, host_ack, mem_wr}); end
    step;
    vectors++; if ({cpu_ack, host_ack, owner} !== 4'b0110) begin miscompares++; $display("FAIL sim_second_ack: got %b want 0110", {cpu_ack, host_ack, owner}); end
    vectors++; if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 8'h02, 16'h2222}) begin miscompares++; $display("FAIL sim_second_cmd: got %h want %h", {mem_wr, mem_addr, mem_wdata}, {1'b1, 8'h02, 16'h2222}); end
    exp_mem[8'h02] = 16'h2222;
    host_req = 1'b0;
    step;
  endtask

  task automatic test_cpu_write_read;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h12; cpu_wdata = 16'hBEEF;
    step;
    vectors++; if ({cpu_ack, mem_wr, mem_addr} !== {1'b1, 1'b1, 8'h12}) begin miscompares++; $display("FAIL wr_ack_cmd: got %h want %h", {cpu_ack, mem_wr, mem_addr}, {1'b1, 1'b1, 8'h12}); end
    exp_mem[8'h12] = 16'hBEEF;
    cpu_req = 1'b0;
    step;
    vectors++; if ({cpu_ack, mem_wr, host_ack, host_rvalid} !== 4'b0) begin miscompares++; $display("FAIL wr_one_cycle: got %b want 0", {cpu_ack, mem_wr, host_ack, host_rvalid}); end
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h12; cpu_wdata = 16'h0000;
    step;
    vectors++; if ({cpu_ack, mem_wr, host_ack, owner} !== 5'b10001) begin miscompares++; $display("FAIL rd_ack: got %b want 10001", {cpu_ack, mem_wr, host_ack, owner}); end
    cpu_req = 1'b0;
    step;
    vectors++; if ({cpu_rvalid, host_rvalid, owner} !== 4'b0001) begin miscompares++; $display("FAIL rd_wait: got %b want 0001", {cpu_rvalid, host_rvalid, owner}); end
    step;
    vectors++; if ({cpu_rvalid, host_rvalid, host_ack} !== 3'b100) begin miscompares++; $display("FAIL rd_rvalid: got %b want 100", {cpu_rvalid, host_rvalid, host_ack}); end
    vectors++; if (rdata !== exp_mem[8'h12]) begin miscompares++; $display("FAIL rd_data: got %h want %h", rdata, exp_mem[8'h12]); end
    step;
    vectors++; if ({cpu_rvalid, rdata} !== {1'b0, exp_mem[8'h12]}) begin miscompares++; $display("FAIL rd_hold: got %h want %h", {cpu_rvalid, rdata}, {1'b0, exp_mem[8'h12]}); end
  endtask

  task automatic test_contention;
    int n;
    int w;
    do_reset;
    n = 0;
    cpu_req = 1'b1;  cpu_wr = 1'b1;  cpu_addr = 8'h60;  cpu_wdata = 16'($urandom);
    host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h70; host_wdata = 16'($urandom);
    for (int i = 0; i < 30 && n < 6; i++) begin
      step;
      if (cpu_ack || host_ack) begin
        w = host_ack ? 1 : 0;
        vectors++; if ((cpu_ack && host_ack) || w != (n % 2)) begin miscompares++; $display("FAIL rr_order: grant %0d got cpu/host %b%b want port %0d", n, cpu_ack, host_ack, n % 2); end
        if (w == 0) begin
          exp_mem[cpu_addr] = cpu_wdata;
          cpu_addr = cpu_addr + 8'h1; cpu_wdata = 16'($urandom);
        end else begin
          exp_mem[host_addr] = host_wdata;
          host_addr = host_addr + 8'h1; host_wdata = 16'($urandom);
        end
        n++;
      end
    end
    vectors++; if (n != 6) begin miscompares++; $display("FAIL rr_timeout: got %0d grants want 6", n); end
    cpu_req = 1'b0;
    host_req = 1'b0;
    step;
  endtask

  task automatic test_read_foreign;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 8'h05;
    step;
    vectors++; if ({host_ack, cpu_ack, owner} !== 4'b1010) begin miscompares++; $display("FAIL rf_host_ack: got %b want 1010", {host_ack, cpu_ack, owner}); end
    host_req = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h30; cpu_wdata = 16'h3C3C;
    step;
    vectors++; if ({cpu_ack, owner} !== 3'b010) begin miscompares++; $display("FAIL rf_rd_cycle: got %b want 010", {cpu_ack, owner}); end
    step;
    vectors++; if ({host_rvalid, cpu_ack, owner} !== 4'b1000) begin miscompares++; $display("FAIL rf_rvalid: got %b want 1000", {host_rvalid, cpu_ack, owner}); end
    vectors++; if (rdata !== 16'h00A5) begin miscompares++; $display("FAIL rf_rdata: got %h want 00a5", rdata); end
    step;
    vectors++; if ({cpu_ack, mem_wr, mem_addr, owner} !== {1'b1, 1'b1, 8'h30, 2'b01}) begin miscompares++; $display("FAIL rf_cpu_ack: got %h want %h", {cpu_ack, mem_wr, mem_addr, owner}, {1'b1, 1'b1, 8'h30, 2'b01}); end
    exp_mem[8'h30] = 16'h3C3C;
    cpu_req = 1'b0;
    step;
  endtask

  task automatic test_reset_mid_write;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h20; cpu_wdata = 16'h3333;
    step;
    vectors++; if ({cpu_ack, mem_wr} !== 2'b11) begin miscompares++; $display("FAIL rmw_in_acc: got %b want 11", {cpu_ack, mem_wr}); end
    #2;
    Reset_n = 1'b0;
    #1;
    vectors++; if ({cpu_ack, host_ack, cpu_rvalid, host_rvalid, mem_wr, owner} !== 7'b0) begin miscompares++; $display("FAIL rmw_ctrl_async: got %b want 0", {cpu_ack, host_ack, cpu_rvalid, host_rvalid, mem_wr, owner}); end
    vectors++; if ({mem_addr, mem_wdata, rdata} !== 40'h0) begin miscompares++; $display("FAIL rmw_data_async: got %h want 0", {mem_addr, mem_wdata, rdata}); end
    cpu_req = 1'b0;
    step;
    vectors++; if (ram[8'h20] !== exp_mem[8'h20]) begin miscompares++; $display("FAIL rmw_ram_kept: got %h want %h", ram[8'h20], exp_mem[8'h20]); end
    Reset_n = 1'b1;
    cpu_req = 1'b1;  cpu_wr = 1'b1;  cpu_addr = 8'h21;  cpu_wdata = 16'h4444;
    host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h22; host_wdata = 16'h5555;
    step;
    vectors++; if ({cpu_ack, host_ack} !== 2'b10) begin miscompares++; $display("FAIL rmw_cpu_tie: got cpu/host %b want 10", {cpu_ack, host_ack}); end
    exp_mem[8'h21] = 16'h4444;
    cpu_req = 1'b0;
    step;
    step;
    vectors++; if (host_ack !== 1'b1) begin miscompares++; $display("FAIL rmw_host_next: got %b want 1", host_ack); end
    exp_mem[8'h22] = 16'h5555;
    host_req = 1'b0;
    step;
  endtask

  task automatic test_dropped_request;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h40; cpu_wdata = 16'hDEAD;
    #3;
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      vectors++; if ({cpu_ack, host_ack, mem_wr, owner} !== 5'b0) begin miscompares++; $display("FAIL drop_ignored: cycle %0d got %b want 0", i, {cpu_ack, host_ack, mem_wr, owner}); end
    end
  endtask

  task automatic test_random;
    logic        r [2];
    logic        w [2];
    logic [7:0]  a [2];
    logic [15:0] d [2];
    int earliest, pend_cyc, own_last, own_port, lastw, p;
    logic [15:0] pend_data;
    logic [1:0]  exp_rv;
    do_reset;
    lastw = 1;
    earliest = cyc + 1;
    pend_cyc = -1;
    own_last = -1;
    own_port = 0;
    pend_data = '0;
    for (int q = 0; q < 2; q++) begin r[q] = 1'b0; w[q] = 1'b0; a[q] = '0; d[q] = '0; end
    for (int i = 0; i < 400; i++) begin
      step;
      if (cpu_ack || host_ack) begin
        p = host_ack ? 1 : 0;
        vectors++; if ((cpu_ack && host_ack) || !r[p] || (r[0] && r[1] && p == lastw) || cyc < earliest) begin miscompares++; $display("FAIL rnd_grant: cyc %0d got ack %b%b req %b%b last %0d", cyc, host_ack, cpu_ack, r[1], r[0], lastw); end
        vectors++; if ({mem_wr, mem_addr, mem_wdata, owner} !== {w[p], a[p], d[p], 2'(p + 1)}) begin miscompares++; $display("FAIL rnd_cmd: cyc %0d got %h want %h", cyc, {mem_wr, mem_addr, mem_wdata, owner}, {w[p], a[p], d[p], 2'(p + 1)}); end
        if (w[p]) begin
          exp_mem[a[p]] = d[p];
          earliest = cyc + 2;
          own_last = cyc;
        end else begin
          pend_cyc = cyc + 2;
          pend_data = exp_mem[a[p]];
          earliest = cyc + 3;
          own_last = cyc + 1;
        end
        own_port = p;
        lastw = p;
        r[p] = 1'b0;
      end else begin
        vectors++; if (cyc >= earliest && (r[0] || r[1])) begin miscompares++; $display("FAIL rnd_missing_ack: cyc %0d got no ack want one for req %b%b", cyc, r[1], r[0]); end
        vectors++; if ({mem_wr, owner} !== {1'b0, (cyc <= own_last) ? 2'(own_port + 1) : 2'b00}) begin miscompares++; $display("FAIL rnd_idle_bus: cyc %0d got %b want %b", cyc, {mem_wr, owner}, {1'b0, (cyc <= own_last) ? 2'(own_port + 1) : 2'b00}); end
      end
      exp_rv = (cyc == pend_cyc) ? ((own_port == 1) ? 2'b10 : 2'b01) : 2'b00;
      vectors++; if ({host_rvalid, cpu_rvalid} !== exp_rv) begin miscompares++; $display("FAIL rnd_rvalid: cyc %0d got %b want %b", cyc, {host_rvalid, cpu_rvalid}, exp_rv); end
      if (cyc == pend_cyc) begin
        vectors++; if (rdata !== pend_data) begin miscompares++; $display("FAIL rnd_rdata: cyc %0d got %h want %h", cyc, rdata, pend_data); end
      end
      for (int q = 0; q < 2; q++) begin
        if (!r[q] && i < 360 && $urandom_range(0, 1) == 1) begin
          r[q] = 1'b1;
          w[q] = 1'($urandom_range(0, 1));
          a[q] = 8'h40 + 8'($urandom_range(0, 15));
          d[q] = 16'($urandom);
        end
      end
      cpu_req = r[0];  cpu_wr = w[0];  cpu_addr = a[0];  cpu_wdata = d[0];
      host_req = r[1]; host_wr = w[1]; host_addr = a[1]; host_wdata = d[1];
    end
    cpu_req = 1'b0;
    host_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    test_reset;
    test_simultaneous;
    test_cpu_write_read;
    test_contention;
    test_read_foreign;
    test_reset_mid_write;
    test_dropped_request;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns want finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 256x16 data memory between the processor controller (CPU port) and a host loader/debug port (HOST port). Each requester issues one access per request/ack handshake. A round-robin FSM grants one access at a time, captures its command, drives the memory for exactly one cycle, and returns read data one cycle later. The block sits between the controller's data-memory signals and the RAM, which has a synchronous write and a 1-cycle registered read.

## Interface
- AW, 8, memory address width
- DW, 16, data width
- clk  in  1  system clock; all state changes on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle pulse; CPU command accepted and issued
- cpu_rvalid  out  1  one-cycle pulse; rdata holds the CPU read result
- host_req, host_wr, host_addr, host_wdata  in  1/1/AW/DW  HOST equivalents of the CPU inputs
- host_ack, host_rvalid  out  1/1  HOST equivalents of the CPU outputs
- rdata  out  DW  last read result, shared by both ports
- mem_addr  out  AW  RAM address
- mem_wr  out  1  RAM write enable
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after the address is presented
- owner  out  2  00 = none, 01 = CPU, 10 = HOST (current ACC/RD owner)

## Operation
- States: IDLE, ACC, RD.
- IDLE: sample cpu_req and host_req.
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the port that is not last_grant.
  - On grant: capture the winner's wr, addr and wdata into command registers, set gnt, then go to ACC.
- ACC: drive mem_addr and mem_wdata from the command registers, and mem_wr = captured wr. Pulse the granted port's ack.
  - Write: last_grant <= gnt, then go to IDLE.
  - Read: go to RD.
- RD: rdata <= mem_rdata, pulse the granted port's rvalid on the following cycle (see Timing), last_grant <= gnt, then go to IDLE.
- mem_wr is 0 in every state except ACC with a captured write.
- mem_addr and mem_wdata hold the command registers in all states.
- owner reflects gnt in ACC and RD, and is 00 in IDLE.
- Requester fields may change freely after ack; the command registers isolate them.
- A req that drops before grant is ignored. No error signalling.
- Reset values: state = IDLE; last_grant = HOST, so the CPU wins the first tie.
- All outputs reset to 0: acks, rvalids, mem_wr, mem_addr, mem_wdata, rdata, owner.

## Timing
- Request sampled in IDLE at cycle T → ack high during T+1 (ACC).
- Write commits at the rising edge ending T+1.
- Read: rdata valid and rvalid high during T+3.
  - Path: RD at T+2 registers mem_rdata; the rvalid pulse is registered alongside it.
  - rdata then holds until the next read completes.
- Throughput: one write per 2 cycles, one read per 3 cycles. IDLE is always visited between accesses.
- Continuous contention alternates grants: CPU, HOST, CPU, … Neither port waits more than one foreign access.
- A request that arrives during ACC or RD waits for the next IDLE.
- Reset asserted mid-operation: the FSM goes immediately and asynchronously to IDLE.
  - mem_wr drops at once; a write in ACC before the edge is aborted.
  - A pending rvalid is suppressed.
  - The requester must re-request after release.
- Reset release: the first sampling IDLE is the first rising edge with Reset_n high.

## Test plan
- CPU write, then read: cpu write 0xBEEF to 0x12, then read 0x12.
  - cpu_ack one cycle after req for each access.
  - mem_wr high exactly 1 cycle, with mem_addr = 0x12.
  - cpu_rvalid two cycles after the read ack, with rdata = 0xBEEF.
  - host_ack and host_rvalid stay 0 throughout.
- Simultaneous first request: both ports request writes (CPU 0x1111 @0x01, HOST 0x2222 @0x02) after reset.
  - CPU acked first; HOST acked 2 cycles later.
  - owner sequence: 01, 00, 10.
- Sustained contention: both ports hold req for 6 accesses.
  - Grant order C, H, C, H, C, H.
  - No port gets two consecutive grants while the other is requesting.
- Read during foreign access: HOST read of 0x05 (preloaded 0x00A5) while the CPU requests a write one cycle later.
  - host_rvalid with rdata = 0x00A5 first.
  - CPU ack in the IDLE+1 cycle after RD.
- Reset mid-write: assert Reset_n low during ACC of a CPU write of 0x3333 @0x20.
  - mem_wr falls immediately.
  - Location 0x20 is unchanged.
  - All outputs are 0 and state is IDLE.
  - After release, the CPU again wins a tie.
- Dropped request: the request drops before the IDLE sample.
  - No ack, no mem_wr.
  - owner stays 00.
